cell_seq_ctrl: RTL and testbench

Sequencer for the BeeF working register and data memory. Executes cell-level ops issued by the decode stage:
- INC/DEC update the working register in place.
- MVR/MVL write the working register back to the current cell if dirty, step the data pointer, then reload the working register from the new cell.

It sits between the decoder, the working-register datapath (source mux plus single register) and the data-memory port, and stalls fetch while a memory sequence is in flight.

---
 rtl/cell_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cell_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_seq_ctrl.sv
// cell_seq_ctrl
// Sequences BeeF cell-level ops against the working register and the data
// memory. INC/DEC complete in the accept cycle. MVR/MVL write a dirty working
// register back, step the data pointer and reload the working register from
// the new cell. FLUSH only writes back. Fetch is stalled through busy while
// a memory sequence is in flight.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   INIT   | load the working register from mem[ptr] after reset
//   IDLE   | accept ops; INC/DEC/NOP finish here without leaving
//   WB     | write the dirty working register back to mem[ptr]
//   RD     | read mem[ptr] into the working register
module cell_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_op_valid,
    input  logic [2:0]        i_op_code,
    output logic              o_busy,
    output logic              o_op_done,
    input  logic [DATA_W-1:0] i_reg_value,
    output logic              o_reg_we,
    output logic              o_reg_src,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_dirty
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WB   = 2'd2,
        S_RD   = 2'd3
    } state_t;

    localparam logic [2:0] OP_INC   = 3'b001;
    localparam logic [2:0] OP_DEC   = 3'b010;
    localparam logic [2:0] OP_MVR   = 3'b011;
    localparam logic [2:0] OP_MVL   = 3'b100;
    localparam logic [2:0] OP_FLUSH = 3'b101;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_dirty;
    logic              r_move;     // latched op: 1 = MVR/MVL, 0 = FLUSH
    logic              r_dir_up;   // latched direction: 1 = MVR, 0 = MVL

    logic              w_accept;
    logic              w_ack;
    logic              w_is_inc;
    logic              w_is_dec;
    logic              w_is_mvr;
    logic              w_is_mvl;
    logic              w_is_move;
    logic              w_is_flush;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [ADDR_W-1:0] w_ptr_dec;
    logic              w_unused_rdata;

    // Read data goes straight to the external source mux; the sequencer never looks at it.
    assign w_unused_rdata = ^i_mem_rdata;

    // Ops and acks are ignored in a reset cycle so a late ack cannot load the register.
    assign w_accept   = i_rst_n & i_op_valid & (r_state == S_IDLE);
    assign w_ack      = i_rst_n & i_mem_ack & o_mem_req;

    assign w_is_inc   = (i_op_code == OP_INC);
    assign w_is_dec   = (i_op_code == OP_DEC);
    assign w_is_mvr   = (i_op_code == OP_MVR);
    assign w_is_mvl   = (i_op_code == OP_MVL);
    assign w_is_move  = w_is_mvr | w_is_mvl;
    assign w_is_flush = (i_op_code == OP_FLUSH);

    assign w_ptr_inc  = r_ptr + PTR_ONE;
    assign w_ptr_dec  = r_ptr - PTR_ONE;

    // busy and the memory port come from registered state only, so no ack-to-busy path.
    assign o_busy      = (r_state != S_IDLE);
    assign o_mem_req   = (r_state != S_IDLE);
    assign o_mem_we    = (r_state == S_WB);
    assign o_mem_addr  = r_ptr;
    // The working register cannot change during WB (reg_we is low there), so wdata stays stable.
    assign o_mem_wdata = i_reg_value;
    assign o_ptr       = r_ptr;
    assign o_dirty     = r_dirty;

    // Register-write strobes and completion pulse for the accept cycle and the ack cycle.
    always_comb begin
        o_reg_we  = 1'b0;
        o_reg_src = 1'b0;
        o_op_done = 1'b0;
        if (w_accept) begin
            if (w_is_inc | w_is_dec) begin
                o_reg_we  = 1'b1;
                o_op_done = 1'b1;
            end else if (w_is_flush) begin
                o_op_done = ~r_dirty;
            end else if (!w_is_move) begin
                o_op_done = 1'b1;
            end
        end
        if (w_ack) begin
            case (r_state)
                S_INIT: begin
                    o_reg_we  = 1'b1;
                    o_reg_src = 1'b1;
                end
                S_WB: o_op_done = ~r_move;
                S_RD: begin
                    o_reg_we  = 1'b1;
                    o_reg_src = 1'b1;
                    o_op_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, data pointer, dirty flag and the latched move op.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_INIT;
            r_ptr    <= '0;
            r_dirty  <= 1'b0;
            r_move   <= 1'b0;
            r_dir_up <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (i_mem_ack) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (i_op_valid) begin
                        if (w_is_inc | w_is_dec) begin
                            r_dirty <= 1'b1;
                        end else if (w_is_move) begin
                            r_move   <= 1'b1;
                            r_dir_up <= w_is_mvr;
                            if (r_dirty) begin
                                r_state <= S_WB;
                            end else begin
                                r_ptr   <= w_is_mvr ? w_ptr_inc : w_ptr_dec;
                                r_state <= S_RD;
                            end
                        end else if (w_is_flush) begin
                            r_move <= 1'b0;
                            if (r_dirty) r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (i_mem_ack) begin
                        r_dirty <= 1'b0;
                        if (r_move) begin
                            r_ptr   <= r_dir_up ? w_ptr_inc : w_ptr_dec;
                            r_state <= S_RD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RD: begin
                    if (i_mem_ack) r_state <= S_IDLE;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_seq_ctrl.sv
// Bench for cell_seq_ctrl: a memory responder with programmable ack latency,
// a bench-side working register driven by the DUT strobes, and a cell-level
// reference model (pointer, dirty flag, register value, memory image).
module tb_cell_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic [2:0] op_code;
    logic       busy, op_done, reg_we, reg_src, mem_req, mem_we, dirty;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, ptr;
    logic       mem_ack;
    logic [7:0] dp_reg;

    int n_vec = 0;
    int n_err = 0;

    // responder / monitor state (written only by the monitor process)
    logic [7:0] mem [256];
    int         we_alu_cnt = 0, we_mem_cnt = 0, done_cnt = 0, busy_cyc = 0, req_cyc = 0;
    logic       tr_we [$];
    logic [7:0] tr_addr [$];
    logic [7:0] tr_data [$];

    // knobs written only by the main process
    int         lat = 1;
    bit         force_ack = 0;

    // reference model (main process only)
    logic [7:0] model_mem [256];
    logic [7:0] m_ptr, m_reg;
    logic       m_dirty;

    cell_seq_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_op_code(op_code),
        .o_busy(busy), .o_op_done(op_done), .i_reg_value(dp_reg),
        .o_reg_we(reg_we), .o_reg_src(reg_src), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .i_mem_ack(mem_ack), .o_ptr(ptr), .o_dirty(dirty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory responder at the falling edge, sampling of strobes 1 ns later,
    // bench working register updated at the rising edge
    initial begin
        int         cnt;
        bit         upd;
        logic [7:0] nxt;
        cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(42 + 158 * i);
        dp_reg = 8'h00;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                cnt = 0;
                mem_ack = force_ack;
                mem_rdata = 8'hEE;
            end else if (mem_req === 1'b1) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem[mem_addr];
                    tr_we.push_back(mem_we);
                    tr_addr.push_back(mem_addr);
                    tr_data.push_back(mem_we ? mem_wdata : mem_rdata);
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                cnt = 0;
                mem_ack = 1'b0;
            end
            #1;
            upd = 0;
            nxt = dp_reg;
            if (reg_we === 1'b1) begin
                upd = 1;
                if (reg_src === 1'b1) begin
                    nxt = mem_rdata;
                    we_mem_cnt++;
                end else begin
                    nxt = (op_code == 3'b010) ? dp_reg - 8'd1 : dp_reg + 8'd1;
                    we_alu_cnt++;
                end
            end
            if (op_done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cyc++;
            if (mem_req === 1'b1) req_cyc++;
            @(posedge clk);
            if (upd) dp_reg = nxt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin
            tick();
            k++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic run_op(input logic [2:0] code, output bit ok);
        op_valid = 1'b1;
        op_code = code;
        tick();
        op_valid = 1'b0;
        wait_idle(ok);
    endtask

    // cell-level semantics of one op
    task automatic model_apply(input logic [2:0] code, output int ew, output int er,
                               output logic [7:0] waddr, output logic [7:0] wdata);
        ew = 0; er = 0; waddr = 8'h00; wdata = 8'h00;
        case (code)
            3'd1: begin m_reg = m_reg + 8'd1; m_dirty = 1'b1; end
            3'd2: begin m_reg = m_reg - 8'd1; m_dirty = 1'b1; end
            3'd3, 3'd4: begin
                if (m_dirty) begin
                    model_mem[m_ptr] = m_reg; ew = 1; waddr = m_ptr; wdata = m_reg;
                end
                m_ptr = (code == 3'd3) ? m_ptr + 8'd1 : m_ptr - 8'd1;
                m_reg = model_mem[m_ptr];
                m_dirty = 1'b0;
                er = 1;
            end
            3'd5: begin
                if (m_dirty) begin
                    model_mem[m_ptr] = m_reg; ew = 1; waddr = m_ptr; wdata = m_reg;
                end
                m_dirty = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic model_op(input logic [2:0] code, output bit ok);
        int ew, er;
        logic [7:0] wa, wd;
        run_op(code, ok);
        model_apply(code, ew, er, wa, wd);
    endtask

    task automatic test_reset();
        bit ok;
        int b_tr, b_done, b_wm;
        rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; lat = 1;
        tick();
        tick();
        b_tr = tr_we.size(); b_done = done_cnt; b_wm = we_mem_cnt;
        rst_n = 1'b1;
        n_vec++; if ({busy, op_done, reg_we, reg_src, dirty, mem_req, mem_we} !== 7'b1000010) begin
            n_err++; $display("FAIL reset_flags: got %b want 1000010", {busy, op_done, reg_we, reg_src, dirty, mem_req, mem_we}); end
        n_vec++; if (ptr !== 8'h00) begin n_err++; $display("FAIL reset_ptr: got %0h want 0", ptr); end
        n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        wait_idle(ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL init_timeout: busy stuck got %b want 0", busy); end
        n_vec++; if (dp_reg !== 8'h2A) begin n_err++; $display("FAIL init_reg: got %0h want 2a", dp_reg); end
        n_vec++; if (tr_we.size() - b_tr !== 1) begin n_err++; $display("FAIL init_ntr: got %0d want 1", tr_we.size() - b_tr); end
        n_vec++; if (we_mem_cnt - b_wm !== 1) begin n_err++; $display("FAIL init_load: got %0d want 1", we_mem_cnt - b_wm); end
        n_vec++; if (done_cnt - b_done !== 0) begin n_err++; $display("FAIL init_done: got %0d want 0", done_cnt - b_done); end
        n_vec++; if ({ptr, dirty} !== 9'h000) begin n_err++; $display("FAIL init_state: got ptr %0h dirty %b want 0 0", ptr, dirty); end
        m_ptr = 8'h00; m_dirty = 1'b0; m_reg = model_mem[0];
    endtask

    task automatic test_inc_dec();
        int b_alu = we_alu_cnt, b_mem = we_mem_cnt, b_done = done_cnt, b_busy = busy_cyc, b_req = req_cyc;
        logic [7:0] exp_reg = m_reg + 8'd1;
        op_valid = 1'b1;
        op_code = 3'b001; tick();
        op_code = 3'b001; tick();
        op_code = 3'b010; tick();
        op_valid = 1'b0;
        n_vec++; if (we_alu_cnt - b_alu !== 3) begin n_err++; $display("FAIL incdec_we: got %0d want 3", we_alu_cnt - b_alu); end
        n_vec++; if (we_mem_cnt - b_mem !== 0) begin n_err++; $display("FAIL incdec_src: got %0d want 0", we_mem_cnt - b_mem); end
        n_vec++; if (done_cnt - b_done !== 3) begin n_err++; $display("FAIL incdec_done: got %0d want 3", done_cnt - b_done); end
        n_vec++; if (busy_cyc - b_busy !== 0) begin n_err++; $display("FAIL incdec_busy: got %0d want 0", busy_cyc - b_busy); end
        n_vec++; if (req_cyc - b_req !== 0) begin n_err++; $display("FAIL incdec_req: got %0d want 0", req_cyc - b_req); end
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL incdec_dirty: got %b want 1", dirty); end
        n_vec++; if (dp_reg !== exp_reg) begin n_err++; $display("FAIL incdec_reg: got %0h want %0h", dp_reg, exp_reg); end
        m_reg = exp_reg; m_dirty = 1'b1;
    endtask

    task automatic test_dirty_mvr();
        bit ok, all_ok;
        int b_tr, b_done, b_busy, b_req;
        lat = 1;
        all_ok = 1;
        model_op(3'd5, ok); all_ok &= ok;
        model_op(3'd3, ok); all_ok &= ok;
        model_op(3'd3, ok); all_ok &= ok;
        model_op(3'd3, ok); all_ok &= ok;
        model_op(3'd1, ok); all_ok &= ok;
        n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL mvr_setup_timeout: got %b want 1", all_ok); end
        n_vec++; if ({ptr, dp_reg, dirty} !== {8'h03, 8'h05, 1'b1}) begin
            n_err++; $display("FAIL mvr_setup: got ptr %0h reg %0h dirty %b want 3 5 1", ptr, dp_reg, dirty); end
        lat = 2;
        b_tr = tr_we.size(); b_done = done_cnt; b_busy = busy_cyc; b_req = req_cyc;
        model_op(3'd3, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL mvr_timeout: got %b want 1", ok); end
        n_vec++; if (tr_we.size() - b_tr !== 2) begin n_err++; $display("FAIL mvr_ntr: got %0d want 2", tr_we.size() - b_tr); end
        if (tr_we.size() - b_tr >= 2) begin
            n_vec++; if ({tr_we[b_tr], tr_addr[b_tr], tr_data[b_tr]} !== {1'b1, 8'h03, 8'h05}) begin
                n_err++; $display("FAIL mvr_write: got we %b addr %0h data %0h want 1 3 5", tr_we[b_tr], tr_addr[b_tr], tr_data[b_tr]); end
            n_vec++; if ({tr_we[b_tr+1], tr_addr[b_tr+1]} !== {1'b0, 8'h04}) begin
                n_err++; $display("FAIL mvr_read: got we %b addr %0h want 0 4", tr_we[b_tr+1], tr_addr[b_tr+1]); end
        end
        n_vec++; if ({ptr, dirty} !== {8'h04, 1'b0}) begin n_err++; $display("FAIL mvr_state: got ptr %0h dirty %b want 4 0", ptr, dirty); end
        n_vec++; if (dp_reg !== m_reg) begin n_err++; $display("FAIL mvr_reg: got %0h want %0h", dp_reg, m_reg); end
        n_vec++; if (done_cnt - b_done !== 1) begin n_err++; $display("FAIL mvr_done: got %0d want 1", done_cnt - b_done); end
        n_vec++; if (busy_cyc - b_busy !== 4) begin n_err++; $display("FAIL mvr_busy_cycles: got %0d want 4", busy_cyc - b_busy); end
        n_vec++; if (req_cyc - b_req !== 4) begin n_err++; $display("FAIL mvr_req_cycles: got %0d want 4", req_cyc - b_req); end
    endtask

    task automatic test_wrap();
        bit ok, all_ok;
        int b_tr;
        lat = 1;
        all_ok = 1;
        for (int i = 0; i < 4; i++) begin model_op(3'd4, ok); all_ok &= ok; end
        n_vec++; if ({all_ok, ptr, dirty} !== {1'b1, 8'h00, 1'b0}) begin
            n_err++; $display("FAIL wrap_setup: got ok %b ptr %0h dirty %b want 1 0 0", all_ok, ptr, dirty); end
        b_tr = tr_we.size();
        model_op(3'd4, ok);
        n_vec++; if ({ok, ptr} !== {1'b1, 8'hFF}) begin n_err++; $display("FAIL wrap_mvl_ptr: got ok %b ptr %0h want 1 ff", ok, ptr); end
        n_vec++; if (tr_we.size() - b_tr !== 1 || tr_addr[b_tr] !== 8'hFF || tr_we[b_tr] !== 1'b0) begin
            n_err++; $display("FAIL wrap_mvl_read: got n %0d addr %0h want 1 ff", tr_we.size() - b_tr, tr_addr[b_tr]); end
        n_vec++; if (dp_reg !== m_reg) begin n_err++; $display("FAIL wrap_mvl_reg: got %0h want %0h", dp_reg, m_reg); end
        b_tr = tr_we.size();
        model_op(3'd3, ok);
        n_vec++; if ({ok, ptr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL wrap_mvr_ptr: got ok %b ptr %0h want 1 0", ok, ptr); end
        n_vec++; if (tr_we.size() - b_tr !== 1 || tr_addr[b_tr] !== 8'h00 || tr_we[b_tr] !== 1'b0) begin
            n_err++; $display("FAIL wrap_mvr_read: got n %0d addr %0h want 1 0", tr_we.size() - b_tr, tr_addr[b_tr]); end
    endtask

    task automatic test_flush();
        bit ok;
        int b_tr, b_done, b_busy, b_req;
        logic [7:0] p0;
        lat = 1;
        model_op(3'd1, ok);
        p0 = m_ptr;
        lat = 3;
        b_tr = tr_we.size(); b_done = done_cnt;
        model_op(3'd5, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL flush_timeout: got %b want 1", ok); end
        n_vec++; if (tr_we.size() - b_tr !== 1 || tr_we[b_tr] !== 1'b1 || tr_addr[b_tr] !== p0 || tr_data[b_tr] !== m_reg) begin
            n_err++; $display("FAIL flush_write: got n %0d we %b addr %0h data %0h want 1 1 %0h %0h",
                              tr_we.size() - b_tr, tr_we[b_tr], tr_addr[b_tr], tr_data[b_tr], p0, m_reg); end
        n_vec++; if ({ptr, dirty} !== {p0, 1'b0}) begin n_err++; $display("FAIL flush_state: got ptr %0h dirty %b want %0h 0", ptr, dirty, p0); end
        n_vec++; if (done_cnt - b_done !== 1) begin n_err++; $display("FAIL flush_done: got %0d want 1", done_cnt - b_done); end
        b_tr = tr_we.size(); b_done = done_cnt; b_busy = busy_cyc; b_req = req_cyc;
        model_op(3'd5, ok);
        n_vec++; if (done_cnt - b_done !== 1) begin n_err++; $display("FAIL flush_clean_done: got %0d want 1", done_cnt - b_done); end
        n_vec++; if ((busy_cyc - b_busy) + (req_cyc - b_req) + (tr_we.size() - b_tr) !== 0) begin
            n_err++; $display("FAIL flush_clean_idle: got busy %0d req %0d tr %0d want 0 0 0",
                              busy_cyc - b_busy, req_cyc - b_req, tr_we.size() - b_tr); end
    endtask

    task automatic test_random();
        bit ok;
        int ew, er, gw, gr, b_tr, b_done;
        logic [2:0] code;
        logic [7:0] wa, wd;
        for (int n = 0; n < 40; n++) begin
            code = 3'($urandom_range(0, 7));
            lat = $urandom_range(1, 4);
            b_tr = tr_we.size(); b_done = done_cnt;
            run_op(code, ok);
            model_apply(code, ew, er, wa, wd);
            gw = 0; gr = 0;
            for (int i = b_tr; i < tr_we.size(); i++) begin
                if (tr_we[i]) gw++; else gr++;
            end
            n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rnd_timeout op %0d: got %b want 1", code, ok); end
            n_vec++; if ({ptr, dirty} !== {m_ptr, m_dirty}) begin
                n_err++; $display("FAIL rnd_state op %0d: got ptr %0h dirty %b want %0h %b", code, ptr, dirty, m_ptr, m_dirty); end
            n_vec++; if (dp_reg !== m_reg) begin n_err++; $display("FAIL rnd_reg op %0d: got %0h want %0h", code, dp_reg, m_reg); end
            n_vec++; if (done_cnt - b_done !== 1) begin n_err++; $display("FAIL rnd_done op %0d: got %0d want 1", code, done_cnt - b_done); end
            n_vec++; if (gw !== ew || gr !== er) begin
                n_err++; $display("FAIL rnd_traffic op %0d: got w %0d r %0d want %0d %0d", code, gw, gr, ew, er); end
            if (ew == 1 && gw == 1) begin
                n_vec++; if ({tr_addr[b_tr], tr_data[b_tr]} !== {wa, wd}) begin
                    n_err++; $display("FAIL rnd_wdata op %0d: got %0h/%0h want %0h/%0h", code, tr_addr[b_tr], tr_data[b_tr], wa, wd); end
            end
        end
    endtask

    task automatic test_reset_mid_rd();
        bit ok;
        int b_tr, b_done, b_we;
        lat = 1;
        model_op(3'd5, ok);
        lat = 100;
        op_valid = 1'b1; op_code = 3'd3;
        tick();
        op_valid = 1'b0;
        tick(); tick();
        n_vec++; if ({busy, mem_req, mem_we} !== 3'b110) begin
            n_err++; $display("FAIL midrd_pending: got busy/req/we %b want 110", {busy, mem_req, mem_we}); end
        b_tr = tr_we.size(); b_done = done_cnt; b_we = we_alu_cnt + we_mem_cnt;
        rst_n = 1'b0; force_ack = 1'b1;
        tick();
        rst_n = 1'b1; force_ack = 1'b0; lat = 1;
        n_vec++; if ({busy, mem_req, mem_we, dirty} !== 4'b1100) begin
            n_err++; $display("FAIL midrd_init_flags: got busy/req/we/dirty %b want 1100", {busy, mem_req, mem_we, dirty}); end
        n_vec++; if ({ptr, mem_addr} !== 16'h0000) begin n_err++; $display("FAIL midrd_init_addr: got ptr %0h addr %0h want 0 0", ptr, mem_addr); end
        n_vec++; if ((done_cnt - b_done) + (we_alu_cnt + we_mem_cnt - b_we) !== 0) begin
            n_err++; $display("FAIL midrd_late_ack: got done %0d we %0d want 0 0", done_cnt - b_done, we_alu_cnt + we_mem_cnt - b_we); end
        wait_idle(ok);
        m_ptr = 8'h00; m_dirty = 1'b0; m_reg = model_mem[0];
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL midrd_timeout: got %b want 1", ok); end
        n_vec++; if (tr_we.size() - b_tr !== 1 || tr_addr[b_tr] !== 8'h00 || tr_we[b_tr] !== 1'b0) begin
            n_err++; $display("FAIL midrd_init_read: got n %0d addr %0h want 1 0", tr_we.size() - b_tr, tr_addr[b_tr]); end
        n_vec++; if (dp_reg !== m_reg) begin n_err++; $display("FAIL midrd_reg: got %0h want %0h", dp_reg, m_reg); end
        n_vec++; if (done_cnt - b_done !== 0) begin n_err++; $display("FAIL midrd_done: got %0d want 0", done_cnt - b_done); end
    endtask

    initial begin
        rst_n = 1'b0;
        op_valid = 1'b0;
        op_code = 3'd0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(42 + 158 * i);
        m_ptr = 8'h00; m_dirty = 1'b0; m_reg = 8'h00;
        test_reset();
        test_inc_dec();
        test_dirty_mvr();
        test_wrap();
        test_flush();
        test_random();
        test_reset_mid_rd();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
